// File: rtl/subleq_ctrl.sv
// subleq_ctrl
//   Control sequencer for the SUBLEQ core. Each instruction is handled in
//   five steps:
//     1. Fetch a 24-bit word from instruction memory at PC.
//     2. Load it into the external instruction register (ireg_24).
//     3. Read mem[A] and mem[B] from data memory.
//     4. Compute mem[B] - mem[A] and write the result back to B.
//     5. Branch to C when the result is <= 0; otherwise fall through to PC+1.
//   A taken branch to 8'hFF halts the core until reset.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   run               start request, only looked at while idle
//   imem_req/addr     instruction fetch request and address (= pc)
//   imem_ack/rdata    fetch completion and fetched word (same cycle)
//   ir_en/ir_in       load strobe and word for ireg_24
//   ir_out            current ireg_24 contents (A = [23:16], B = [15:8], C = [7:0])
//   dmem_req/we       data access request; we = 1 for write
//   dmem_addr/wdata   data address and write data, stable while requested
//   dmem_ack/rdata    access completion and read data (same cycle)
//   pc                program counter
//   busy              high in every state except IDLE and HALT
//   halted            high in HALT
//   retired           completed-instruction count, wraps at 16 bits
//
// Every output is either a register or a decode of the state register, so an
// ack can only influence the outputs through a clock edge.
module subleq_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        run,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [23:0] imem_rdata,
    output logic        ir_en,
    output logic [23:0] ir_in,
    input  logic [23:0] ir_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [7:0]  dmem_wdata,
    input  logic        dmem_ack,
    input  logic [7:0]  dmem_rdata,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        READ_A = 3'd3,
        READ_B = 3'd4,
        EXEC   = 3'd5,
        WRITE  = 3'd6,
        HALT   = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        a_fld;
    logic [7:0]        b_fld;
    logic [7:0]        c_fld;
    logic signed [7:0] op_a;
    logic signed [7:0] op_b;
    logic signed [7:0] diff;
    logic signed [7:0] res;
    logic              leq;

    // Result <= 0 in 8-bit two's complement: negative or exactly zero.
    function automatic logic is_leq(input logic signed [7:0] v);
        return (v <= 8'sd0);
    endfunction

    // Branch target when taken, otherwise fall through with 8-bit wrap.
    function automatic logic [7:0] next_pc(input logic [7:0] cur,
                                           input logic       taken,
                                           input logic [7:0] target);
        return taken ? target : (cur + 8'd1);
    endfunction

    assign a_fld = ir_out[23:16];
    assign b_fld = ir_out[15:8];
    assign c_fld = ir_out[7:0];

    // Modulo-256 subtraction; the wrap is the intended SUBLEQ behaviour.
    assign diff = op_b - op_a;

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (run)      state_next = FETCH;
            FETCH:  if (imem_ack) state_next = LOAD;
            LOAD:                 state_next = READ_A;
            READ_A: if (dmem_ack) state_next = READ_B;
            READ_B: if (dmem_ack) state_next = EXEC;
            EXEC:                 state_next = WRITE;
            WRITE: begin
                if (dmem_ack) begin
                    state_next = (leq && (c_fld == 8'hFF)) ? HALT : FETCH;
                end
            end
            HALT:                 state_next = HALT;
            default:              state_next = IDLE;
        endcase
    end

    // ---------------- decoded outputs ----------------
    // ir_out is only valid once READ_A is entered, which is exactly when the
    // data address starts being taken from it.
    always_comb begin
        imem_req  = (state == FETCH);
        ir_en     = (state == LOAD);
        dmem_req  = (state == READ_A) || (state == READ_B) || (state == WRITE);
        dmem_we   = (state == WRITE);
        busy      = (state != IDLE) && (state != HALT);
        halted    = (state == HALT);
        imem_addr = pc;
        dmem_addr = 8'h00;
        case (state)
            READ_A:         dmem_addr = a_fld;
            READ_B, WRITE:  dmem_addr = b_fld;
            default:        dmem_addr = 8'h00;
        endcase
    end

    assign dmem_wdata = res;

    // ---------------- control and visible registers ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc      <= 8'h00;
            retired <= 16'h0000;
            ir_in   <= 24'h000000;
            res     <= 8'sd0;
            leq     <= 1'b0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                ir_in <= imem_rdata;
            end
            if (state == EXEC) begin
                res <= diff;
                leq <= is_leq(diff);
            end
            if ((state == WRITE) && dmem_ack) begin
                pc      <= next_pc(pc, leq, c_fld);
                retired <= retired + 16'd1;
            end
        end
    end

    // ---------------- operand registers ----------------
    // Pure data: always written before use within an instruction.
    always_ff @(posedge CLK) begin
        if ((state == READ_A) && dmem_ack) begin
            op_a <= $signed(dmem_rdata);
        end
        if ((state == READ_B) && dmem_ack) begin
            op_b <= $signed(dmem_rdata);
        end
    end

endmodule

// File: tb/tb_subleq_ctrl.sv
module tb_subleq_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [23:0] imem_rdata;
    logic        ir_en;
    logic [23:0] ir_in;
    logic [23:0] ir_out = 24'h000000;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack;
    logic [7:0]  dmem_rdata;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    subleq_ctrl dut (
        .CLK(CLK), .RST(RST), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_en(ir_en), .ir_in(ir_in), .ir_out(ir_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 CLK = ~CLK;

    // ireg_24 model
    always @(posedge CLK) if (ir_en) ir_out <= ir_in;

    logic [23:0] imem [256];
    logic [7:0]  dmem [256];
    int          lat     = 1;
    int          i_limit = 0;
    logic        i_force = 1'b0;

    int tests = 0;
    int fails = 0;

    // instruction memory responder
    logic        i_ack = 1'b0;
    logic [23:0] i_rd = 24'h0;
    int          i_cnt = 0;
    int          i_served = 0;
    int          i_unst = 0;
    logic [7:0]  i_addr_l = 8'h0;
    assign imem_ack   = i_ack | i_force;
    assign imem_rdata = i_rd;

    always @(negedge CLK) begin
        if (i_ack) begin i_ack = 1'b0; i_cnt = 0; end
        if (imem_req && (i_served < i_limit)) begin
            if (i_cnt == 0) i_addr_l = imem_addr;
            else if (imem_addr !== i_addr_l) i_unst++;
            i_cnt++;
            if (i_cnt == lat + 1) begin
                i_ack = 1'b1;
                i_rd  = imem[imem_addr];
                i_served++;
            end
        end else begin
            i_cnt = 0;
        end
    end

    // data memory responder; writes are recorded, not stored
    logic       d_ack = 1'b0;
    logic [7:0] d_rd = 8'h0;
    int         d_cnt = 0;
    int         d_unst = 0;
    logic [7:0] d_addr_l = 8'h0;
    logic       d_we_l = 1'b0;
    logic [7:0] d_wd_l = 8'h0;
    logic [7:0] w_addr = 8'h0;
    logic [7:0] w_data = 8'h0;
    int         w_cnt = 0;
    assign dmem_ack   = d_ack;
    assign dmem_rdata = d_rd;

    always @(negedge CLK) begin
        if (d_ack) begin d_ack = 1'b0; d_cnt = 0; end
        if (dmem_req) begin
            if (d_cnt == 0) begin
                d_addr_l = dmem_addr; d_we_l = dmem_we; d_wd_l = dmem_wdata;
            end else if ((dmem_addr !== d_addr_l) || (dmem_we !== d_we_l) ||
                         (dmem_we && (dmem_wdata !== d_wd_l))) begin
                d_unst++;
            end
            d_cnt++;
            if (d_cnt == lat + 1) begin
                d_ack = 1'b1;
                if (dmem_we) begin
                    w_addr = dmem_addr; w_data = dmem_wdata; w_cnt++;
                end else begin
                    d_rd = dmem[dmem_addr];
                end
            end
        end else begin
            d_cnt = 0;
        end
    end

    // protocol monitor
    int both_cnt = 0;
    int ir_en_cnt = 0;
    int req_cnt = 0;
    always @(negedge CLK) begin
        if (imem_req && dmem_req) both_cnt++;
        if (ir_en) ir_en_cnt++;
        if (imem_req || dmem_req) req_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1; run = 1'b0;
        @(negedge CLK); RST = 1'b0;
    endtask

    // leaves the caller at the negedge of the first FETCH cycle
    task automatic start();
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
    endtask

    // counts cycles until the next FETCH is entered or HALT is reached
    task automatic run_until_done(output int cyc);
        logic [15:0] r0;
        int n;
        r0 = retired;
        n = 0;
        while (n < 400) begin
            @(negedge CLK);
            n++;
            if (halted || (imem_req && (retired !== r0))) break;
        end
        cyc = n;
    endtask

    int cyc;
    int snap;

    initial begin
        for (int i = 0; i < 256; i++) begin imem[i] = 24'h0; dmem[i] = 8'h0; end
        dmem[1] = 8'd3;  dmem[2] = 8'd10; dmem[3] = 8'd9;
        dmem[4] = 8'd5;  dmem[6] = 8'd2;  dmem[7] = 8'd1; dmem[8] = 8'd1;
        dmem[9] = 8'd44; dmem[10] = 8'd1; dmem[11] = 8'd5;
        dmem[12] = 8'd2; dmem[13] = 8'd7;

        // reset values
        @(negedge CLK); @(negedge CLK);
        check("rst_outs", {imem_req, dmem_req, dmem_we, ir_en, busy, halted}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_data", {ir_in, imem_addr}, 32'h0);
        check("rst_daddr_wdata", {dmem_addr, dmem_wdata}, 32'h0);
        RST = 1'b0;

        // reset mid-FETCH, then a late ack
        imem[0] = 24'h010205;
        i_limit = 0;
        start();
        check("fetch_req", {imem_req, busy}, 32'h3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_fetch", {imem_req, busy}, 32'h0);
        check("rst_mid_pc", pc, 32'h0);
        i_force = 1'b1;
        @(negedge CLK);
        i_force = 1'b0;
        @(negedge CLK);
        check("late_ack_ignored", {imem_req, ir_en, busy, dmem_req}, 32'h0);
        check("late_ack_state", {retired, ir_in[15:0]}, 32'h0);

        // run and RST together: reset wins
        run = 1'b1; RST = 1'b1;
        @(negedge CLK);
        run = 1'b0; RST = 1'b0;
        @(negedge CLK);
        check("run_rst_same", {busy, imem_req}, 32'h0);

        // not-taken instruction
        do_reset();
        lat = 1; i_limit = i_served + 1;
        snap = ir_en_cnt;
        start();
        run_until_done(cyc);
        check("nt_cycles", cyc, 32'd10);
        check("nt_write", {w_addr, w_data}, 32'h0207);
        check("nt_pc", pc, 32'h01);
        check("nt_retired", retired, 32'h1);
        check("nt_ir_en_once", ir_en_cnt - snap, 32'h1);
        check("nt_imem_addr", {imem_addr, busy, halted}, {22'h0, 8'h01, 2'b10});

        // taken on zero
        do_reset();
        imem[0] = 24'h030305; i_limit = i_served + 1;
        start();
        run_until_done(cyc);
        check("zero_write", {w_addr, w_data}, 32'h0300);
        check("zero_pc", pc, 32'h05);

        // taken on negative
        do_reset();
        imem[0] = 24'h04060A; i_limit = i_served + 1;
        start();
        run_until_done(cyc);
        check("neg_write", {w_addr, w_data}, 32'h06FD);
        check("neg_pc", pc, 32'h0A);

        // halt
        do_reset();
        imem[0] = 24'h0708FF; i_limit = i_served + 1;
        start();
        run_until_done(cyc);
        check("halt_cycles", cyc, 32'd10);
        check("halt_write", {w_addr, w_data}, 32'h0800);
        check("halt_pc", pc, 32'hFF);
        check("halt_flags", {halted, busy}, 32'h2);
        check("halt_retired", retired, 32'h1);
        i_limit = i_served + 4;
        snap = req_cnt;
        run = 1'b1;
        @(negedge CLK); @(negedge CLK);
        run = 1'b0;
        repeat (4) @(negedge CLK);
        check("halt_no_req", req_cnt - snap, 32'h0);
        check("halt_sticky", {halted, busy, pc}, {22'h0, 2'b10, 8'hFF});

        // branch to FE, not-taken with C=FF, then stalled wrap at FF
        do_reset();
        imem[0]   = 24'h0909FE;
        imem[254] = 24'h0A0BFF;
        imem[255] = 24'h0C0D00;
        lat = 1; i_limit = i_served + 2;
        start();
        run_until_done(cyc);
        check("br_fe_pc", pc, 32'hFE);
        run_until_done(cyc);
        check("cff_not_halt", {halted, busy, pc}, {22'h0, 2'b01, 8'hFF});
        check("cff_write", {w_addr, w_data}, 32'h0B04);
        check("cff_retired", retired, 32'h2);
        force dut.retired = 16'hFFFF;
        @(negedge CLK);
        release dut.retired;
        @(negedge CLK);
        check("preset_retired", retired, 32'hFFFF);
        lat = 3;
        @(posedge CLK); #1;
        i_limit = i_served + 1;
        snap = w_cnt;
        @(negedge CLK);
        run_until_done(cyc);
        check("stall_cycles", cyc, 32'd18);
        check("wrap_pc", pc, 32'h00);
        check("wrap_retired", retired, 32'h0);
        check("stall_write", {w_addr, w_data}, 32'h0D05);
        check("stall_one_write", w_cnt - snap, 32'h1);
        check("stable_reqs", i_unst + d_unst, 32'h0);
        check("req_exclusive", both_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Control sequencer for the SUBLEQ core. It fetches 24-bit instruction words, loads them into the 24-bit instruction register (`ireg_24`) through its enable, and reads operands from data memory. It then performs `mem[B] = mem[B] - mem[A]`, writes the result back, and branches to C when the result is less than or equal to zero. It sits between the instruction/data memories and `ireg_24`, and owns the PC and the retired-instruction counter.

## Interface
- No parameters; all widths are fixed by the 24-bit instruction format (A = ir[23:16], B = ir[15:8], C = ir[7:0]).
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `run`  in  1  start request; sampled only in IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  8  fetch address (= PC).
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  24  fetched instruction word.
- `ir_en`  out  1  load enable to `ireg_24`.
- `ir_in`  out  24  instruction word to `ireg_24`.
- `ir_out`  in  24  `ireg_24` contents.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = write, 0 = read; valid while `dmem_req` is high.
- `dmem_addr`  out  8  data address.
- `dmem_wdata`  out  8  write data.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle for reads.
- `dmem_rdata`  in  8  read data.
- `pc`  out  8  current PC.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `retired`  out  16  count of completed instructions.

## Operation
- States and transitions:
  - IDLE: `run`=1 → FETCH.
  - FETCH: hold `imem_req`=1, `imem_addr`=pc. On `imem_ack` capture `imem_rdata` into the fetch register → LOAD.
  - LOAD: `ir_en`=1 for exactly one cycle, `ir_in`=fetch register → READ_A.
  - READ_A: `dmem_req`=1, `dmem_we`=0, `dmem_addr`=ir_out[23:16]. On ack latch opA → READ_B.
  - READ_B: same read with `dmem_addr`=ir_out[15:8]. On ack latch opB → EXEC.
  - EXEC: one cycle. res = opB - opA, 8-bit two's complement, wraps modulo 256. leq = res[7] | (res==0) → WRITE.
  - WRITE: `dmem_req`=1, `dmem_we`=1, `dmem_addr`=ir_out[15:8], `dmem_wdata`=res. On ack, update pc and `retired`, then:
    - leq and C==8'hFF → HALT;
    - otherwise → FETCH.
  - HALT: sticky; only `RST` exits.
- PC update:
  - leq=1: pc = C.
  - leq=0: pc = pc+1, which wraps 8'hFF → 8'h00.
- C==8'hFF with leq=0 does not halt.
- `retired` increments by 1 per completed WRITE, including the halting instruction; wraps 16'hFFFF → 0.
- `ir_en` is never asserted outside LOAD.
- `dmem_addr`, `dmem_we` and `dmem_wdata` are stable for the whole request.
- `imem_req` and `dmem_req` are never high simultaneously.
- A=B is legal: the result is 0, so leq=1 and the branch is always taken.
- Acks received in states that are not waiting for them are ignored. An ack never completes a request in the cycle after the state exits.
- `run` deasserting mid-instruction has no effect. The controller returns to IDLE only via `RST`.

## Timing
- Reset values: state IDLE; `pc`=0, `retired`=0; `imem_req`, `dmem_req`, `dmem_we`, `ir_en`, `busy`, `halted` all 0; `ir_in`, `imem_addr`, `dmem_addr`, `dmem_wdata` all 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from ack to any output.
- Requests:
  - A request asserts on the clock edge entering its state.
  - Ack may arrive no earlier than the cycle after the request asserts, and may be delayed arbitrarily.
  - The request drops on the edge after ack is sampled.
- With 1-cycle ack latency, one instruction takes 10 cycles: FETCH 2, LOAD 1, READ_A 2, READ_B 2, EXEC 1, WRITE 2.
- `ir_out` is valid from the first cycle of READ_A, because `ireg_24` loads on the LOAD→READ_A edge.
- `RST` in any state: on the next edge all outputs take their reset values and any in-flight request is abandoned. A late ack arriving after reset is ignored.
- `run` and `RST` high in the same cycle: `RST` wins.

## Test plan
- Reset mid-FETCH: assert `RST` for 1 cycle while `imem_req`=1 → next cycle `imem_req`=0, pc=0, state IDLE. A late ack the following cycle is ignored; `retired` stays 0.
- Not-taken instruction: pc=0, instr 24'h010205, mem[1]=3, mem[2]=10, 1-cycle acks → write to address 2 with data 7; pc=1; retired=1; exactly 10 cycles from FETCH entry; `ir_en` high exactly once.
- Taken branch on zero: instr 24'h030305, mem[3]=9 → write 0 to address 3; pc=5.
- Taken branch on negative: instr 24'h04060A, mem[4]=5, mem[6]=2 → write 8'hFD; pc=0x0A.
- Halt: instr 24'h0708FF, mem[7]=1, mem[8]=1 → write 0; pc=0xFF; `halted`=1, `busy`=0. `run` pulses are then ignored and no further requests are issued until `RST`.
- Stalled acks and wrap: 3-cycle ack latency on all ports with pc=0xFF and a not-taken instruction → requests held stable for 3 cycles each; pc wraps to 0x00. Preset `retired`=16'hFFFF via 65535 prior instructions → it wraps to 0.
